// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Holds the FSM state encoding, the default operand width and a magnitude helper.
package sdiv_pkg;

  localparam int DEF_W = 16;
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Callers sign-extend a narrower word to MAX_W and cast the result back.
  // The most negative word then yields its true unsigned magnitude.
  function automatic logic [MAX_W-1:0] magnitude(input logic signed [MAX_W-1:0] x);
    logic [MAX_W-1:0] ux;
    ux = x;
    return x[MAX_W-1] ? (~ux + MAX_W'(1)) : ux;
  endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Shifts {P,A} left by one and keeps the trial subtraction only when it is non-negative.
module sdiv_step
  import sdiv_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W:0]   p,
  input  logic [W-1:0] a,
  input  logic [W-1:0] d,
  output logic [W:0]   p_next,
  output logic [W-1:0] a_next
);

  logic [W+1:0] p_sh;
  logic [W+1:0] trial;

  // One guard bit above the partial remainder carries the trial sign.
  always_comb begin
    p_sh   = {p, a[W-1]};
    trial  = p_sh - {2'b00, d};
    a_next = {a[W-2:0], ~trial[W+1]};
    p_next = trial[W+1] ? p_sh[W:0] : trial[W:0];
  end

endmodule

// File: rtl/sdiv_datapath.sv
// Sequential signed divider: restoring algorithm on magnitudes, one quotient bit
// per clock, followed by sign correction and divide-by-zero / overflow flagging.
module sdiv_datapath
  import sdiv_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] dividend,
  input  logic signed [W-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] quotient,
  output logic signed [W-1:0] remainder,
  output logic                div_by_zero,
  output logic                overflow
);

  localparam logic [CW-1:0]       LAST    = CW'(W - 1);
  localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_t state, state_nx;

  logic signed [W-1:0] dvd_raw;
  logic signed [W-1:0] dvs_raw;
  logic [W:0]          p_reg;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        d_reg;
  logic [CW-1:0]       count;
  logic [W:0]          p_next;
  logic [W-1:0]        a_next;
  logic                neg_q;
  logic                neg_r;

  sdiv_step #(.W(W)) u_step (
    .p      (p_reg),
    .a      (a_reg),
    .d      (d_reg),
    .p_next (p_next),
    .a_next (a_next)
  );

  assign neg_q = dvd_raw[W-1] ^ dvs_raw[W-1];
  assign neg_r = dvd_raw[W-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (divisor == '0) ? FIX : ABS;
      ABS:  state_nx = ITER;
      ITER: if (count == LAST) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand and iteration registers: no reset, their contents are only
  // consumed in states reachable after an accepted start.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          dvd_raw <= dividend;
          dvs_raw <= divisor;
        end
      end
      ABS: begin
        a_reg <= W'(magnitude(MAX_W'(dvd_raw)));
        d_reg <= W'(magnitude(MAX_W'(dvs_raw)));
        p_reg <= '0;
        count <= '0;
      end
      ITER: begin
        p_reg <= p_next;
        a_reg <= a_next;
        count <= count + CW'(1);
      end
      default: ;
    endcase
  end

  // Result stage: outputs are registered at FIX and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ABS) busy <= 1'b1;
      if (state == FIX) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (dvs_raw == '0) begin
          quotient    <= '1;
          remainder   <= dvd_raw;
          div_by_zero <= 1'b1;
          overflow    <= 1'b0;
        end else begin
          quotient    <= $signed(neg_q ? (~a_reg + W'(1)) : a_reg);
          remainder   <= $signed(neg_r ? (~p_reg[W-1:0] + W'(1)) : p_reg[W-1:0]);
          div_by_zero <= 1'b0;
          overflow    <= (dvd_raw == MOST_NEG) && (dvs_raw == '1);
        end
      end
    end
  end

endmodule

// File: doc/sdiv_datapath.md
Name: sdiv_datapath

Overview:
- Sequential signed integer divider datapath. It consumes the dividend and divisor words that the divider controller loads from data_in, and produces quotient and remainder.
- Uses a restoring algorithm on operand magnitudes, retiring one quotient bit per clock, then applies the sign correction.
- Sits directly downstream of the divider controller. Its start/busy/done handshake is what the controller sequences.

Parameters:
- W, 16, operand/result width in bits (two's complement); must be >= 2.
- CW, 5, iteration counter width; must satisfy 2**CW > W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  W  signed dividend; captured on the accepted start edge.
- divisor  input  W  signed divisor; captured on the accepted start edge.
- busy  output  1  high from the edge after an accepted start until done is raised.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  W  signed quotient, truncated toward zero.
- remainder  output  W  signed remainder; sign follows the dividend.
- div_by_zero  output  1  divisor was 0 for the last operation.
- overflow  output  1  last operation was -2**(W-1) / -1.

Behaviour:
- Reset: busy, done, div_by_zero and overflow = 0; quotient and remainder = 0; state IDLE.
  - Applies mid-operation: the operation is aborted and no done is issued.
- States:
  - IDLE: on start, latch operands and their sign bits.
    - If divisor == 0, go to FIX (zero path).
    - Otherwise go to ABS. Set busy = 1.
  - ABS: replace each operand by its magnitude as an unsigned W-bit value (0x8000 -> 32768 for W=16). Clear the partial remainder (W+1 bits) and set count = 0. Go to ITER.
  - ITER: shift {P,A} left by 1.
    - Trial = P - D. If trial >= 0, set P = trial and A[0] = 1; otherwise A[0] = 0.
    - count++. After W iterations, go to FIX.
  - FIX: register outputs, pulse done, clear busy, return to IDLE.
    - Normal path: quotient = A, negated if the operand signs differ. Remainder = P[W-1:0], negated if the dividend is negative.
    - Zero path: quotient = all ones, remainder = dividend, div_by_zero = 1.
- Latency, start sampled at edge k:
  - Normal: done is high after edge k+W+2, i.e. 18 edges for W=16.
  - Divide by zero: done is high after edge k+1.
- done is high for exactly one cycle. quotient, remainder and the flags hold until the next accepted start's FIX.
- div_by_zero and overflow are recomputed at every FIX.
- start while busy (any state other than IDLE) is ignored. Operand changes during busy have no effect.
- start in the same cycle that done is high is accepted, because the state is already IDLE.
- Overflow: for -2**(W-1) / -1, quotient = 0x8000 (wrapped), remainder = 0, overflow = 1.
- Special cases:
  - Dividend 0: quotient = 0, remainder = 0, no flags.
  - |dividend| < |divisor|: quotient = 0, remainder = dividend.
- Arithmetic width rules:
  - The partial remainder is W+1 bits so no trial subtraction is lost.
  - Negation is two's complement modulo 2**W.

Decomposition:
- Package sdiv_pkg holds:
  - State enum IDLE/ABS/ITER/FIX.
  - Default W.
  - A function returning the W-bit magnitude of a signed word.
- One natural sub-module: sdiv_step, purely combinational, one restoring iteration: in {P,A,D}, out {P',A'}. The top keeps the FSM, counter and sign fix-up.

Test Plan:
- 100 / 7 -> quotient = 14 (0x000E), remainder = 2, no flags; done exactly 18 edges after start; busy high for 17 cycles before done.
- -100 / 7 -> quotient 0xFFF2 (-14), remainder 0xFFFE (-2).
- 100 / -7 -> quotient -14, remainder 2.
- -100 / -7 -> quotient 14, remainder 0xFFFE.
- 1234 / 0 -> div_by_zero = 1, quotient = 0xFFFF, remainder = 0x04D2; done 1 edge after start.
- Next op 5/5 -> quotient 1, remainder 0, div_by_zero returns to 0.
- -32768 / -1 -> quotient 0x8000, remainder 0, overflow = 1.
- -32768 / 1 -> quotient 0x8000, overflow = 0.
- 7 / 100 -> quotient 0, remainder 7.
- Start 500/3, assert rst at the 5th ITER cycle -> next cycle busy = 0 and all outputs 0; no done pulse in the following 20 cycles.
- Pulse start with 9/2 during busy -> ignored, so the original 100/7 results appear.
- Back-to-back: start held high on the done cycle -> second operation completes 18 edges later.
